// File: rtl/icache_refill_responder.sv
// Instruction-cache refill responder: fetches one cache line (or one word when uncached)
// as XLEN-wide memory beats and returns the assembled block over a valid/ready handshake.
module icache_refill_responder #(
    parameter int XLEN       = 32,
    parameter int BLK_SIZE   = 128,
    parameter int MAX_OUTSTD = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                lx_ireq_valid_i,
    input  logic                lx_ireq_ready_i,
    input  logic [XLEN-1:0]     lx_ireq_addr_i,
    input  logic                lx_ireq_uncached_i,
    output logic                lx_ires_ready_o,
    output logic                lx_ires_valid_o,
    output logic [BLK_SIZE-1:0] lx_ires_blk_o,
    output logic                lx_ires_err_o,
    output logic                mem_req_o,
    output logic [XLEN-1:0]     mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    input  logic                mem_err_i
);

    localparam int BEATS = BLK_SIZE / XLEN;
    localparam int OFFW  = $clog2(BLK_SIZE / 8);
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [XLEN-1:0]     r_base;
    logic [IW-1:0]       r_start;
    logic [CW-1:0]       r_n;
    logic [CW-1:0]       r_issued;
    logic [CW-1:0]       r_received;
    logic [CW-1:0]       r_outstd;
    logic [BLK_SIZE-1:0] r_blk;
    logic                r_err;

    logic                w_accept;
    logic                w_wantReq;
    logic                w_gnt;
    logic                w_rvalid;
    logic                w_drainRv;
    logic [CW-1:0]       w_issuedNext;
    logic [CW-1:0]       w_receivedNext;
    logic [IW-1:0]       w_issueIdx;
    logic [IW-1:0]       w_slot;
    logic [XLEN-1:0]     w_reqAddr;
    logic                w_unused;

    assign w_accept       = (r_state == S_IDLE) && lx_ireq_valid_i && !flush_i;
    assign w_wantReq      = (r_state == S_ISSUE) && (r_issued < r_n) && (r_outstd < CW'(MAX_OUTSTD));
    // A grant seen in a flush cycle is still counted so DRAIN waits for its data.
    assign w_gnt          = w_wantReq && mem_gnt_i;
    assign w_rvalid       = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && mem_rvalid_i;
    assign w_drainRv      = (r_state == S_DRAIN) && mem_rvalid_i && (r_outstd != '0);
    assign w_issuedNext   = r_issued + CW'(w_gnt);
    assign w_receivedNext = r_received + CW'(w_rvalid);
    assign w_issueIdx     = r_start + r_issued[IW-1:0];
    assign w_slot         = r_start + r_received[IW-1:0];
    assign w_reqAddr      = r_base + (XLEN'(w_issueIdx) << 2);
    assign w_unused       = ^lx_ireq_addr_i[1:0];

    assign mem_addr_o     = mem_req_o ? w_reqAddr : '0;
    assign lx_ires_blk_o  = r_blk;
    assign lx_ires_err_o  = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        lx_ires_ready_o = 1'b0;
        lx_ires_valid_o = 1'b0;
        mem_req_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                lx_ires_ready_o = 1'b1;
                if (w_accept) begin
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req_o = w_wantReq && !flush_i;
                if (flush_i) begin
                    w_nextState = ((r_outstd != '0) || w_gnt) ? S_DRAIN : S_IDLE;
                end else if (w_issuedNext == r_n) begin
                    w_nextState = (w_receivedNext == r_n) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    w_nextState = (r_outstd != '0) ? S_DRAIN : S_IDLE;
                end else if (w_receivedNext == r_n) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                lx_ires_valid_o = 1'b1;
                if (flush_i || lx_ireq_ready_i) begin
                    w_nextState = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (r_outstd == '0) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_base     <= '0;
            r_start    <= '0;
            r_n        <= '0;
            r_issued   <= '0;
            r_received <= '0;
            r_outstd   <= '0;
            r_blk      <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_base     <= {lx_ireq_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
            r_start    <= lx_ireq_uncached_i ? IW'(lx_ireq_addr_i[OFFW-1:2]) : '0;
            r_n        <= lx_ireq_uncached_i ? CW'(1) : CW'(BEATS);
            r_issued   <= '0;
            r_received <= '0;
            r_outstd   <= '0;
            r_blk      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_issued   <= w_issuedNext;
            r_received <= w_receivedNext;
            r_outstd   <= r_outstd + CW'(w_gnt) - CW'(w_rvalid || w_drainRv);
            if (w_rvalid) begin
                r_blk[w_slot*XLEN +: XLEN] <= mem_rdata_i;
                r_err                      <= r_err | mem_err_i;
            end
        end
    end

endmodule
